// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the ADD_SUB mantissa path: default widths, chunk count
// helper, FSM state encoding and the full-adder cell the subtractor is built from.
package fp_addsub_pkg;

   localparam int WIDTH_DEF = 26;
   localparam int CHUNK_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SUB  = 2'd1;
   localparam logic [1:0] ST_NEG  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic int calc_nchunk(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

   // Returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
      return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
   endfunction

endpackage

// File: rtl/mant_sub_serial_chunk.sv
// CHUNK-bit ripple-borrow subtractor (x - y - bin) built from full adders with
// y inverted and carry-in = ~bin; bout is taken at bit TOP_BITS-1 for the top chunk.
module sub_chunk
   import fp_addsub_pkg::*;
#(
   parameter int CHUNK    = CHUNK_DEF,
   parameter int TOP_BITS = CHUNK_DEF
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             bin,
   input  logic             is_top,
   output logic [CHUNK-1:0] d,
   output logic             bout
);

   always_comb begin
      logic       carry;
      logic       top_carry;
      logic [1:0] fa;
      carry     = ~bin;
      top_carry = 1'b0;
      d         = '0;
      for (int i = 0; i < CHUNK; i++) begin
         fa    = full_add(x[i], ~y[i], carry);
         d[i]  = fa[0];
         carry = fa[1];
         if (i == TOP_BITS - 1) top_carry = carry;
      end
      bout = is_top ? ~top_carry : ~carry;
   end

endmodule

// File: rtl/mant_sub_serial.sv
// Chunk-serial magnitude subtractor: diff = |a - b|, neg = (a < b), zero = (a == b),
// with a second pass over the shared chunk subtractor to negate a borrowed result.
module mant_sub_serial
   import fp_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             neg,
   output logic             zero
);

   localparam int NCHUNK   = calc_nchunk(WIDTH, CHUNK);
   localparam int PW       = NCHUNK * CHUNK;
   localparam int TOP_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
   localparam int IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   logic [1:0]       state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [PW-1:0]    raw_q, raw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             neg_q, neg_d;
   logic             zero_q, zero_d;

   logic [PW-1:0]    a_pad, b_pad;
   logic [CHUNK-1:0] chunk_x, chunk_y, chunk_d;
   logic             chunk_bout, is_top;
   int               base;

   assign a_pad  = PW'(a_q);
   assign b_pad  = PW'(b_q);
   assign is_top = (idx_q == IDXW'(NCHUNK - 1));
   assign base   = int'(idx_q) * CHUNK;

   // The NEG pass reuses the same subtractor as 0 - raw, overwriting raw in place.
   always_comb begin
      chunk_x = '0;
      chunk_y = b_pad[base +: CHUNK];
      if (state_q == ST_NEG) begin
         chunk_y = raw_q[base +: CHUNK];
      end else begin
         chunk_x = a_pad[base +: CHUNK];
      end
   end

   sub_chunk #(
      .CHUNK   (CHUNK),
      .TOP_BITS(TOP_BITS)
   ) u_sub_chunk (
      .x     (chunk_x),
      .y     (chunk_y),
      .bin   (borrow_q),
      .is_top(is_top),
      .d     (chunk_d),
      .bout  (chunk_bout)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      raw_d    = raw_q;
      diff_d   = diff_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = 1'b0;
               idx_d    = '0;
               state_d  = ST_SUB;
            end
         end
         ST_SUB, ST_NEG: begin
            raw_d[base +: CHUNK] = chunk_d;
            borrow_d             = chunk_bout;
            if (!is_top) begin
               idx_d = idx_q + IDXW'(1);
            end else if (state_q == ST_SUB && chunk_bout) begin
               neg_d    = 1'b1;
               borrow_d = 1'b0;
               idx_d    = '0;
               state_d  = ST_NEG;
            end else begin
               diff_d  = raw_d[WIDTH-1:0];
               zero_d  = (raw_d[WIDTH-1:0] == '0);
               if (state_q == ST_SUB) neg_d = 1'b0;
               state_d = ST_DONE;
            end
         end
         default: begin
            if (out_ready) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         raw_q    <= '0;
         diff_q   <= '0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         raw_q    <= raw_d;
         diff_q   <= diff_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign diff      = diff_q;
   assign neg       = neg_q;
   assign zero      = zero_q;

endmodule
